// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared opcodes, functs, FSM states and ALU operation codes for the multi-cycle MIPS core
package mips_mc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_LUI} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32x32 register file, two async read ports, one sync write port, $0 hardwired to zero
module mips_mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;

  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS subset core with a single shared memory port and a sticky trap state
module mips_mc_core import mips_mc_pkg::*; #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] pc_o,
  output logic        trap
);
  state_t      state;
  alu_op_t     aop;
  logic [31:0] ir, a, b, imm, pc4, res, wcnt;
  logic [31:0] rd1, rd2, opb, alu_y, ext, ctrl_tgt, rf_wd;
  logic [5:0]  op, fn;
  logic [4:0]  rf_wa;
  logic        is_r, is_jr, r_alu, is_ctrl, is_mem, legal, jr_bad, tmo, rf_we;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign is_r    = op == OP_RTYPE;
  assign r_alu   = is_r && ir[10:6] == 5'd0 &&
                   (fn == FN_ADDU || fn == FN_SUBU || fn == FN_SLT || fn == FN_AND || fn == FN_OR);
  assign is_jr   = is_r && fn == FN_JR;
  assign is_mem  = op == OP_LW || op == OP_SW;
  assign is_ctrl = is_jr || op == OP_BEQ || op == OP_J || op == OP_JAL;
  assign legal   = r_alu || is_ctrl || is_mem || op == OP_ORI || op == OP_LUI || op == OP_ADDIU;
  assign jr_bad  = is_jr && a[1:0] != 2'b00;
  assign tmo     = MEM_TIMEOUT != 0 && mem_req && !mem_ready && wcnt == MEM_TIMEOUT;
  assign ext     = op == OP_ORI ? {16'h0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};

  assign aop = !is_r ? (op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD) :
               fn == FN_SUBU ? ALU_SUB : fn == FN_SLT ? ALU_SLT :
               fn == FN_AND  ? ALU_AND : fn == FN_OR  ? ALU_OR  : ALU_ADD;
  assign opb   = is_r ? b : imm;
  assign alu_y = aop == ALU_SUB ? a - opb :
                 aop == ALU_SLT ? {31'b0, $signed(a) < $signed(opb)} :
                 aop == ALU_AND ? a & opb :
                 aop == ALU_OR  ? a | opb :
                 aop == ALU_LUI ? {imm[15:0], 16'h0} : a + opb;

  assign ctrl_tgt = is_jr ? a :
                    (op == OP_J || op == OP_JAL) ? {pc4[31:28], ir[25:0], 2'b00} :
                    a == b ? pc4 + {imm[29:0], 2'b00} : pc4;

  // jal links during EXEC; everything else writes back in WB
  assign rf_we = state == S_WB || (state == S_EXEC && op == OP_JAL);
  assign rf_wa = state == S_EXEC ? 5'd31 : is_r ? ir[15:11] : ir[20:16];
  assign rf_wd = state == S_EXEC ? pc4 : res;
  assign retire = state == S_WB || (state == S_EXEC && is_ctrl && !jr_bad) ||
                  (state == S_MEM && mem_we && mem_ready);

  mips_mc_regfile u_rf (
    .clk(clk), .rst(rst), .ra1(ir[25:21]), .ra2(ir[20:16]), .rd1(rd1), .rd2(rd2),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE; pc_o <= RESET_PC; trap <= 1'b0; wcnt <= '0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      ir <= '0; a <= '0; b <= '0; imm <= '0; pc4 <= '0; res <= '0;
    end else begin
      wcnt <= (mem_req && !mem_ready) ? wcnt + 32'd1 : '0;
      case (state)
        S_IDLE: begin
          state <= S_FETCH; mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc_o;
        end
        S_FETCH:
          if (mem_ready) begin
            ir <= mem_rdata; mem_req <= 1'b0; state <= S_DECODE;
          end else if (tmo) begin
            state <= S_TRAP; trap <= 1'b1; mem_req <= 1'b0;
          end
        S_DECODE: begin
          a <= rd1; b <= rd2; pc4 <= pc_o + 32'd4; imm <= ext;
          state <= legal ? S_EXEC : S_TRAP;
          trap <= !legal;
        end
        S_EXEC:
          if (is_ctrl ? jr_bad : is_mem && alu_y[1:0] != 2'b00) begin
            state <= S_TRAP; trap <= 1'b1;
          end else if (is_ctrl) begin
            pc_o <= ctrl_tgt; state <= S_FETCH; mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= ctrl_tgt;
          end else if (is_mem) begin
            state <= S_MEM; mem_req <= 1'b1; mem_we <= op == OP_SW; mem_addr <= alu_y; mem_wdata <= b;
          end else begin
            res <= alu_y; state <= S_WB;
          end
        S_MEM:
          if (mem_ready && mem_we) begin
            pc_o <= pc4; state <= S_FETCH; mem_we <= 1'b0; mem_addr <= pc4;
          end else if (mem_ready) begin
            res <= mem_rdata; mem_req <= 1'b0; state <= S_WB;
          end else if (tmo) begin
            state <= S_TRAP; trap <= 1'b1; mem_req <= 1'b0; mem_we <= 1'b0;
          end
        S_WB: begin
          pc_o <= pc4; state <= S_FETCH; mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc4;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: ALU vector table, randomized ALU ops against a reference model, and multi-cycle sequences
module tb_mips_mc_core;
  localparam logic [5:0] LUI = 6'h0f, ORI = 6'h0d, ADDIU = 6'h09, BEQ = 6'h04, LW = 6'h23, SW = 6'h2b, JAL = 6'h03;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a, F_AND = 6'h24, F_OR = 6'h25, F_JR = 6'h08;

  logic        clk = 1'b0, rst = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, retire, trap;
  logic [31:0] mem_addr, mem_wdata, pc_o, mem_rdata = '0;
  int nchk = 0, nerr = 0, cyc = 0, waited = 0, slow_cnt = 0;
  logic [31:0] slow_addr = 32'hffff_fffc;
  logic [31:0] mem [256];
  logic [31:0] prog [$];
  logic [31:0] ret_pc [$];
  int          ret_cyc [$];
  logic        cont = 1'b0, s_we = 1'b0, bad_req = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0;

  typedef struct {string name; int kind; logic [31:0] a, b; logic [15:0] im; logic [31:0] exp;} vec_t;
  vec_t tbl [10];

  mips_mc_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_o(pc_o), .trap(trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // memory: zero wait except slow_addr, which holds mem_ready low for slow_cnt cycles
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      mem_ready = 1'b0; waited = 0;
    end else begin
      if (mem_ready) waited = 0;
      if (mem_addr == slow_addr && waited < slow_cnt) begin
        mem_ready = 1'b0; waited++;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && retire) begin
      ret_pc.push_back(pc_o); ret_cyc.push_back(cyc);
    end
    if (rst && mem_req) begin
      if (cont) begin
        chk("hold_addr", mem_addr, s_addr);
        chk("hold_wdata", mem_wdata, s_wdata);
        chk("hold_we", {31'b0, mem_we}, {31'b0, s_we});
      end
      cont = !mem_ready; s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
      if (mem_addr[1:0] != 2'b00) bad_req = 1'b1;
    end else cont = 1'b0;
  end

  function automatic logic [31:0] rt_(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] enc(input int kind, input logic [15:0] im);
    case (kind)
      0: return rt_(1, 2, 3, F_ADDU);
      1: return rt_(1, 2, 3, F_SUBU);
      2: return rt_(1, 2, 3, F_SLT);
      3: return rt_(1, 2, 3, F_AND);
      4: return rt_(1, 2, 3, F_OR);
      5: return it(ADDIU, 1, 3, im);
      6: return it(ORI, 1, 3, im);
      default: return it(LUI, 0, 3, im);
    endcase
  endfunction
  function automatic logic [31:0] ref_op(input int kind, input logic [31:0] a, b, input logic [15:0] im);
    case (kind)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return a & b;
      4: return a | b;
      5: return a + {{16{im[15]}}, im};
      6: return a | {16'h0, im};
      default: return {im, 16'h0};
    endcase
  endfunction

  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    for (int i = 0; i < 256; i++) mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    ret_pc.delete(); ret_cyc.delete(); bad_req = 1'b0; cont = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ret(input int n, input int budget, input string name);
    int k = 0;
    while (ret_pc.size() < n && k < budget) begin
      @(negedge clk); #3; k++;
    end
    nchk++;
    if (ret_pc.size() < n) begin
      nerr++;
      $display("FAIL %s: %0d retires, required %0d", name, ret_pc.size(), n);
    end
  endtask

  task automatic run_alu(input string name, input int kind, input logic [31:0] a, b,
                         input logic [15:0] im, input logic [31:0] exp);
    prog = '{it(LUI, 0, 1, a[31:16]), it(ORI, 1, 1, a[15:0]), it(LUI, 0, 2, b[31:16]),
             it(ORI, 2, 2, b[15:0]), enc(kind, im), it(BEQ, 0, 0, 16'hffff)};
    start();
    wait_ret(6, 80, name);
    chk(name, dut.u_rf.regs[3], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"addu_wrap",  0, 32'hffff_ffff, 32'h0000_0001, 16'h0000, 32'h0000_0000};
    tbl[1] = '{"subu_wrap",  1, 32'h0000_0000, 32'h0000_0001, 16'h0000, 32'hffff_ffff};
    tbl[2] = '{"slt_neg",    2, 32'hffff_ffff, 32'h0000_0001, 16'h0000, 32'h0000_0001};
    tbl[3] = '{"slt_pos",    2, 32'h0000_0001, 32'hffff_ffff, 16'h0000, 32'h0000_0000};
    tbl[4] = '{"and",        3, 32'hf0f0_1234, 32'h0ff0_ff00, 16'h0000, 32'h00f0_1200};
    tbl[5] = '{"or",         4, 32'hf000_0000, 32'h0000_000f, 16'h0000, 32'hf000_000f};
    tbl[6] = '{"addiu_sext", 5, 32'h0000_0010, 32'h0,         16'hffff, 32'h0000_000f};
    tbl[7] = '{"ori_zext",   6, 32'h0001_0000, 32'h0,         16'h8000, 32'h0001_8000};
    tbl[8] = '{"lui",        7, 32'h0000_0005, 32'h0,         16'h1234, 32'h1234_0000};
    tbl[9] = '{"addiu_wrap", 5, 32'h7fff_ffff, 32'h0,         16'h0001, 32'h8000_0000};
    for (int i = 0; i < 10; i++) run_alu(tbl[i].name, tbl[i].kind, tbl[i].a, tbl[i].b, tbl[i].im, tbl[i].exp);

    for (int i = 0; i < 30; i++) begin
      int k;
      logic [31:0] ra, rb;
      logic [15:0] im;
      k = $urandom_range(0, 7); ra = $urandom; rb = $urandom; im = 16'($urandom);
      run_alu("rand_alu", k, ra, rb, im, ref_op(k, ra, rb, im));
    end

    // three-instruction program: 4 cycles each after the IDLE cycle
    prog = '{it(ORI, 0, 1, 16'h5), it(ORI, 0, 2, 16'h7), rt_(1, 2, 3, F_ADDU), it(BEQ, 0, 0, 16'hffff)};
    start();
    wait_ret(4, 40, "prog3_ret");
    chk("prog3_ret2_cycle", 32'(ret_cyc[1]), 32'd8);
    chk("prog3_ret3_cycle", 32'(ret_cyc[2]), 32'd12);
    chk("prog3_r3", dut.u_rf.regs[3], 32'hc);

    slow_addr = 32'h10; slow_cnt = 3;
    prog = '{it(ORI, 0, 3, 16'hc), it(SW, 0, 3, 16'h10), it(LW, 0, 4, 16'h10), it(BEQ, 0, 0, 16'hffff)};
    start();
    wait_ret(4, 60, "slow_ret");
    chk("sw_ret_cycle", 32'(ret_cyc[1]), 32'd11);
    chk("lw_cycles", 32'(ret_cyc[2] - ret_cyc[1]), 32'd8);
    chk("sw_mem", mem[4], 32'hc);
    chk("lw_r4", dut.u_rf.regs[4], 32'hc);
    slow_addr = 32'hffff_fffc;

    prog = '{it(ORI, 0, 1, 16'h5), it(ORI, 0, 2, 16'h1), it(BEQ, 1, 1, 16'hffff)};
    start();
    wait_ret(7, 60, "beq_self_ret");
    for (int k = 2; k < 7; k++) chk("beq_self_pc", ret_pc[k], 32'h8);
    for (int k = 3; k < 7; k++) chk("beq_self_period", 32'(ret_cyc[k] - ret_cyc[k-1]), 32'd3);

    prog = '{{JAL, 26'h10}, it(ORI, 0, 5, 16'h77), it(BEQ, 0, 0, 16'hffff)};
    for (int i = 3; i < 16; i++) prog.push_back(32'h0);
    prog.push_back(rt_(31, 0, 0, F_JR));
    start();
    wait_ret(5, 60, "jal_jr_ret");
    chk("jal_pc", ret_pc[0], 32'h0);
    chk("jr_pc", ret_pc[1], 32'h40);
    chk("resume_pc", ret_pc[2], 32'h4);
    chk("jal_r31", dut.u_rf.regs[31], 32'h4);
    chk("resume_r5", dut.u_rf.regs[5], 32'h77);

    prog = '{it(ORI, 0, 1, 16'h5), it(ORI, 0, 2, 16'h7), rt_(1, 2, 0, F_ADDU), rt_(0, 1, 6, F_ADDU), it(BEQ, 0, 0, 16'hffff)};
    start();
    wait_ret(5, 50, "r0_ret");
    chk("r0_write_retire_cycle", 32'(ret_cyc[2]), 32'd12);
    chk("r0_reads_zero", dut.u_rf.regs[6], 32'h5);
    chk("r0_storage", dut.u_rf.regs[0], 32'h0);

    prog = '{32'hfc00_0000};
    start();
    repeat (8) @(negedge clk);
    #3;
    chk("illegal_trap", {31'b0, trap}, 32'd1);
    chk("illegal_mem_req", {31'b0, mem_req}, 32'd0);
    chk("illegal_pc", pc_o, 32'h0);
    chk("illegal_retires", 32'(ret_pc.size()), 32'd0);

    prog = '{it(LW, 0, 1, 16'h2)};
    start();
    repeat (8) @(negedge clk);
    #3;
    chk("lw_misalign_trap", {31'b0, trap}, 32'd1);
    chk("lw_misalign_no_req", {31'b0, bad_req}, 32'd0);
    chk("lw_misalign_pc", pc_o, 32'h0);
    chk("lw_misalign_mem_req", {31'b0, mem_req}, 32'd0);

    prog = '{it(ORI, 0, 1, 16'h2), rt_(1, 0, 0, F_JR)};
    start();
    repeat (12) @(negedge clk);
    #3;
    chk("jr_misalign_trap", {31'b0, trap}, 32'd1);
    chk("jr_misalign_pc", pc_o, 32'h4);

    // fetch of 0x4 starts in cycle 5; the 17th low cycle is cycle 21
    slow_addr = 32'h4; slow_cnt = 17;
    prog = '{it(ORI, 0, 1, 16'h1), it(ORI, 0, 2, 16'h2), it(BEQ, 0, 0, 16'hffff)};
    start();
    begin
      int k = 0;
      while (cyc < 21 && k < 100) begin @(negedge clk); #3; k++; end
    end
    chk("tmo_cycle", 32'(cyc), 32'd21);
    chk("tmo_not_yet", {31'b0, trap}, 32'd0);
    @(negedge clk); #3;
    chk("tmo_trap", {31'b0, trap}, 32'd1);
    chk("tmo_mem_req", {31'b0, mem_req}, 32'd0);
    chk("tmo_pc", pc_o, 32'h4);
    repeat (5) @(negedge clk);
    #3;
    chk("tmo_sticky", {31'b0, trap}, 32'd1);
    chk("tmo_no_retire", {31'b0, retire}, 32'd0);

    slow_cnt = 16;
    start();
    wait_ret(3, 80, "wait16_ret");
    chk("wait16_no_trap", {31'b0, trap}, 32'd0);

    slow_cnt = 17;
    start();
    repeat (8) @(negedge clk);
    chk("async_pre_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_drop_req", {31'b0, mem_req}, 32'd0);
    chk("async_pc", pc_o, 32'h0);
    slow_addr = 32'hffff_fffc; slow_cnt = 0;
    prog = '{it(BEQ, 0, 0, 16'hffff)};
    start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
